dog_window_gen: RTL and testbench

Builds the 3x3x3 scale-space neighbourhood consumed by the extrema detector from three raster-aligned DoG layer streams. Each layer passes through a two-row line buffer and a 3-column shift window. One fully interior window per accepted pixel is presented, with a single-cycle valid, on the `oData_a` / `oData_b0`..`oData_b26` bus. It sits between the DoG subtractors and the extrema detector, and is the producer side of that detector's `iDval` / `iData_*` interface.

---
 rtl/sift_pkg.sv | 13 +
 rtl/dog_window_gen_if.sv | 33 +++
 rtl/dog_line_buffer.sv | 42 ++++
 rtl/dog_window_gen.sv | 82 ++++++++
 tb/tb_dog_window_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT scale-space datapath: default sample width,
// 3x3x3 window indexing and the flattened window type.
package sift_pkg;

  localparam int DATA_W           = 8;
  localparam int WIN_SIZE         = 27;
  localparam int WIN_CENTRE_IDX   = 13;
  localparam int WIN_LAYER_STRIDE = 9;

  // Index k = layer*WIN_LAYER_STRIDE + row*3 + col, row/col 0 = top/left.
  typedef logic [WIN_SIZE-1:0][DATA_W-1:0] win_t;

endpackage

// File: rtl/dog_window_gen_if.sv
// Bus between DoG subtractors, window generator and extrema detector.
// Optional oRow/oCol exist only when DOG_WIN_COORD_EN is defined.
interface dog_window_gen_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = sift_pkg::DATA_W
);

  logic                                      iDval;
  logic [DATA_W-1:0]                         iData_s0;
  logic [DATA_W-1:0]                         iData_s1;
  logic [DATA_W-1:0]                         iData_s2;
  logic                                      oDval;
  logic [DATA_W-1:0]                         oData_a;
  // oData_b[k] carries neighbourhood sample b<k>.
  logic [sift_pkg::WIN_SIZE-1:0][DATA_W-1:0] oData_b;

`ifdef DOG_WIN_COORD_EN
  logic [$clog2(IMG_HEIGHT)-1:0]             oRow;
  logic [$clog2(IMG_WIDTH)-1:0]              oCol;

  modport master (output iDval, iData_s0, iData_s1, iData_s2,
                  input  oDval, oData_a, oData_b, oRow, oCol);
  modport slave  (input  iDval, iData_s0, iData_s1, iData_s2,
                  output oDval, oData_a, oData_b, oRow, oCol);
`else
  modport master (output iDval, iData_s0, iData_s1, iData_s2,
                  input  oDval, oData_a, oData_b);
  modport slave  (input  iDval, iData_s0, iData_s1, iData_s2,
                  output oDval, oData_a, oData_b);
`endif

endinterface

// File: rtl/dog_line_buffer.sv
// One DoG layer: two-row delay addressed by column plus a 3x3 window whose
// newest column is presented combinationally so the top can register it.
module dog_line_buffer #(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = sift_pkg::DATA_W
) (
  input  logic                             iclk,
  input  logic                             iEn,
  input  logic [$clog2(IMG_WIDTH)-1:0]     iCol,
  input  logic [DATA_W-1:0]                iData,
  output logic [8:0][DATA_W-1:0]           oWin
);

  logic [DATA_W-1:0]      rowDly1 [IMG_WIDTH];
  logic [DATA_W-1:0]      rowDly2 [IMG_WIDTH];
  logic [2:0][DATA_W-1:0] colNew_p0;
  logic [2:0][DATA_W-1:0] colMid_p1;
  logic [2:0][DATA_W-1:0] colOld_p1;

  // Element 0 is the oldest row (r-2), element 2 the incoming row r.
  assign colNew_p0 = {iData, rowDly1[iCol], rowDly2[iCol]};

  // p0 -> p1: row delays and window columns advance only on accepted pixels
  always_ff @(posedge iclk) begin
    if (iEn) begin
      rowDly1[iCol] <= iData;
      rowDly2[iCol] <= rowDly1[iCol];
      colOld_p1     <= colMid_p1;
      colMid_p1     <= colNew_p0;
    end
  end

  always_comb begin
    oWin = '0;
    for (int k = 0; k < 3; k++) begin
      oWin[k*3 + 0] = colOld_p1[k];
      oWin[k*3 + 1] = colMid_p1[k];
      oWin[k*3 + 2] = colNew_p0[k];
    end
  end

endmodule

// File: rtl/dog_window_gen.sv
// 3x3x3 DoG neighbourhood generator feeding the extrema detector.
// Define DOG_WIN_COORD_EN to add the oRow/oCol centre-coordinate outputs.
module dog_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = sift_pkg::DATA_W
) (
  input  logic             iclk,
  input  logic             irst,
  dog_window_gen_if.slave  bus
);

  import sift_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]                    col;
  logic [RW-1:0]                    row;
  logic                             accept_p0;
  logic                             vld_p0;
  logic [2:0][DATA_W-1:0]           layerIn;
  logic [2:0][8:0][DATA_W-1:0]      win_p0;

  assign accept_p0 = bus.iDval && !irst;
  // Interior only: rows/cols 0 and 1 would mix previous-row or previous-frame data.
  assign vld_p0    = accept_p0 && (row >= RW'(2)) && (col >= CW'(2));
  assign layerIn   = {bus.iData_s2, bus.iData_s1, bus.iData_s0};

  for (genvar l = 0; l < 3; l++) begin : gLayer
    dog_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH),
      .DATA_W    (DATA_W)
    ) uLineBuf (
      .iclk  (iclk),
      .iEn   (accept_p0),
      .iCol  (col),
      .iData (layerIn[l]),
      .oWin  (win_p0[l])
    );
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      col <= '0;
      row <= '0;
    end else if (bus.iDval) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // p0 -> p1: output registers load only when a complete interior window exists
  always_ff @(posedge iclk) begin
    if (irst) begin
      bus.oDval   <= 1'b0;
      bus.oData_a <= '0;
      bus.oData_b <= '0;
`ifdef DOG_WIN_COORD_EN
      bus.oRow    <= '0;
      bus.oCol    <= '0;
`endif
    end else begin
      bus.oDval <= vld_p0;
      if (vld_p0) begin
        bus.oData_a <= win_p0[WIN_CENTRE_IDX / WIN_LAYER_STRIDE][WIN_CENTRE_IDX % WIN_LAYER_STRIDE];
        bus.oData_b <= win_p0;
`ifdef DOG_WIN_COORD_EN
        bus.oRow    <= row - RW'(1);
        bus.oCol    <= col - CW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_dog_window_gen.sv
// Scoreboard bench for dog_window_gen on an 8x6 ramp image; coordinate
// outputs are checked too when DOG_WIN_COORD_EN is defined.
module tb_dog_window_gen;

  import sift_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    win_t       b;
    int         r;
    int         c;
    int         firstA;
  } exp_t;

  logic iclk;
  logic irst;
  int   cycCnt = 0;
  int   nChecks = 0;
  int   nPass = 0;
  int   pulseCnt = 0;
  int   expPulses = 0;
  int   markNext = -1;
  bit   monOn = 0;
  logic [7:0] holdA;
  win_t       holdB;
  int         holdR;
  int         holdC;
  exp_t       q[$];

  dog_window_gen_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) bus ();

  dog_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;
  always @(posedge iclk) cycCnt <= cycCnt + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    nChecks++;
    if (got !== want)
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    else
      nPass++;
  endtask

  function automatic logic [7:0] pix(input int l, input int r, input int c, input int off);
    return 8'(r*8 + c + 64*l + off);
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic idleCycle();
    step();
    bus.iDval = 1'b0;
  endtask

  task automatic drivePix(input int r, input int c, input int off);
    exp_t e;
    step();
    bus.iDval    = 1'b1;
    bus.iData_s0 = pix(0, r, c, off);
    bus.iData_s1 = pix(1, r, c, off);
    bus.iData_s2 = pix(2, r, c, off);
    if (r >= 2 && c >= 2) begin
      for (int l = 0; l < 3; l++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.b[l*9 + i*3 + j] = pix(l, r-2+i, c-2+j, off);
      e.a      = pix(1, r-1, c-1, off);
      e.r      = r - 1;
      e.c      = c - 1;
      e.cyc    = cycCnt + 1;
      e.firstA = markNext;
      markNext = -1;
      q.push_back(e);
      expPulses++;
    end
  endtask

  task automatic runFrame(input int off, input bit gapped);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gapped)
          for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) idleCycle();
        drivePix(r, c, off);
      end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_dval"}, 256'(bus.oDval), 256'(0));
    chk({tag, "_a"}, 256'(bus.oData_a), 256'(0));
    chk({tag, "_b"}, 256'(bus.oData_b), 256'(0));
`ifdef DOG_WIN_COORD_EN
    chk({tag, "_row"}, 256'(bus.oRow), 256'(0));
    chk({tag, "_col"}, 256'(bus.oCol), 256'(0));
`endif
  endtask

  // Output monitor: pops on every pulse, otherwise checks that outputs hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge iclk);
      if (monOn) begin
        if (bus.oDval) begin
          pulseCnt++;
          if (q.size() == 0) begin
            chk("spurious_dval", 256'(1), 256'(0));
          end else begin
            e = q.pop_front();
            chk("latency", 256'(cycCnt), 256'(e.cyc));
            chk("data_a", 256'(bus.oData_a), 256'(e.a));
            chk("data_b", 256'(bus.oData_b), 256'(e.b));
            if (e.firstA >= 0) chk("first_a", 256'(bus.oData_a), 256'(e.firstA));
`ifdef DOG_WIN_COORD_EN
            chk("row", 256'(bus.oRow), 256'(e.r));
            chk("col", 256'(bus.oCol), 256'(e.c));
`endif
            holdA = e.a;
            holdB = e.b;
            holdR = e.r;
            holdC = e.c;
          end
        end else begin
          chk("hold_a", 256'(bus.oData_a), 256'(holdA));
          chk("hold_b", 256'(bus.oData_b), 256'(holdB));
`ifdef DOG_WIN_COORD_EN
          chk("hold_row", 256'(bus.oRow), 256'(holdR));
          chk("hold_col", 256'(bus.oCol), 256'(holdC));
`endif
        end
      end
    end
  end

  initial begin
    int p0;
    irst         = 1'b1;
    bus.iDval    = 1'b0;
    bus.iData_s0 = '0;
    bus.iData_s1 = '0;
    bus.iData_s2 = '0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chkZero("reset");
    holdA = '0; holdB = '0; holdR = 0; holdC = 0;
    monOn = 1'b1;
    step();
    irst = 1'b0;
    idleCycle();

    // Ramp frame, continuous input
    p0 = pulseCnt;
    markNext = 73;
    runFrame(0, 1'b0);
    idleCycle(); idleCycle();
    chk("ramp_pulses", 256'(pulseCnt - p0), 256'(24));

    // Same frame with random input gaps
    p0 = pulseCnt;
    markNext = 73;
    runFrame(0, 1'b1);
    idleCycle(); idleCycle();
    chk("gap_pulses", 256'(pulseCnt - p0), 256'(24));

    // Back-to-back frames, second one offset by +1
    p0 = pulseCnt;
    runFrame(0, 1'b0);
    markNext = 74;
    runFrame(1, 1'b0);
    idleCycle(); idleCycle();
    chk("b2b_pulses", 256'(pulseCnt - p0), 256'(48));

    // Reset asserted for one cycle while pixel (3,4) is presented
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (!(r == 3 && c >= 4)) drivePix(r, c, 0);
    step();
    irst         = 1'b1;
    bus.iDval    = 1'b1;
    bus.iData_s0 = pix(0, 3, 4, 0);
    bus.iData_s1 = pix(1, 3, 4, 0);
    bus.iData_s2 = pix(2, 3, 4, 0);
    step();
    irst      = 1'b0;
    bus.iDval = 1'b0;
    holdA = '0; holdB = '0; holdR = 0; holdC = 0;
    @(negedge iclk);
    chkZero("midrst");
    p0 = pulseCnt;
    markNext = 73;
    runFrame(0, 1'b0);
    idleCycle(); idleCycle(); idleCycle();
    chk("postrst_pulses", 256'(pulseCnt - p0), 256'(24));
    chk("queue_empty", 256'(q.size()), 256'(0));
    chk("total_pulses", 256'(pulseCnt), 256'(expPulses));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", nChecks);
    $fatal(1, "timeout");
  end

endmodule
